// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the alu_pipe block and its benches.
//   ALU_WIDTH   - default datapath width
//   alu_op_e    - 4-bit opcode encoding seen on alu_pipe.operation
//   alu_state_e - control FSM states of alu_pipe
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SRA  = 4'b1000,
        OP_SLTU = 4'b1001,
        OP_MUL  = 4'b1010,
        OP_NOR  = 4'b1100
    } alu_op_e;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier, one partial product per cycle.
// Returns the low WIDTH bits of a*b (identical for signed and unsigned).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - load operands and begin (ignored bits of state are cleared)
//   a, b        - multiplicand, multiplier
//   done        - one-cycle pulse; product is final while done is high
//   product     - accumulated product
module alu_mul_seq import alu_pkg::*; #(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic             busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc    <= '0;
                mcand  <= a;
                mplier <= b;
                cnt    <= '0;
                busy   <= 1'b1;
            end else if (busy) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (cnt == LAST) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign product = acc;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready ALU with a registered result stage.
// Single-cycle ops produce a result one edge after acceptance; MUL (only when
// the macro ALU_PIPE_MUL_EN is defined) runs on alu_mul_seq and completes
// WIDTH+1 edges after acceptance. Without the macro opcode 1010 is illegal.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - request handshake for operation, A, B
//   operation            - 4-bit opcode (alu_pkg::alu_op_e)
//   A, B                 - operands
//   out_valid/out_ready  - result handshake
//   ALUResult            - registered result
//   zero, overflow, illegal - registered flags accompanying ALUResult
module alu_pipe import alu_pkg::*; #(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam int unsigned SHW = $clog2(WIDTH);

    alu_state_e       state;
    alu_state_e       state_next;
    logic             accept;
    logic             is_mul;
    logic             mul_load;
    logic [WIDTH-1:0] mul_product;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic             ill;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign shamt    = B[SHW-1:0];
    assign sum      = A + B;
    assign diff     = A - B;

    always_comb begin
        res = '0;
        ovf = 1'b0;
        ill = 1'b0;
        case (operation)
            OP_AND:  res = A & B;
            OP_OR:   res = A | B;
            OP_XOR:  res = A ^ B;
            OP_NOR:  res = ~(A | B);
            OP_SLL:  res = A << shamt;
            OP_SRL:  res = A >> shamt;
            OP_SRA:  res = $signed(A) >>> shamt;
            OP_ADD: begin
                res = sum;
                ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                res = diff;
                ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, A < B};
`ifdef ALU_PIPE_MUL_EN
            OP_MUL:  res = '0;
`endif
            default: ill = 1'b1;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    logic mul_start;
    logic mul_done;

    assign is_mul   = (operation == OP_MUL);
    assign mul_load = (state == MUL_RUN) && mul_done;

    always_comb begin
        state_next = state;
        mul_start  = 1'b0;
        case (state)
            IDLE: begin
                if (accept && is_mul) begin
                    state_next = MUL_RUN;
                    mul_start  = 1'b1;
                end
            end
            MUL_RUN: begin
                if (mul_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign is_mul      = 1'b0;
    assign mul_load    = 1'b0;
    assign mul_product = '0;

    always_comb begin
        state_next = IDLE;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A MUL is only accepted when the output stage is empty or draining, so
    // out_valid is already low by the time the multiplier result is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            ALUResult <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
        end else if (accept && !is_mul) begin
            out_valid <= 1'b1;
            ALUResult <= res;
            zero      <= (res == '0);
            overflow  <= ovf;
            illegal   <= ill;
        end else if (mul_load) begin
            out_valid <= 1'b1;
            ALUResult <= mul_product;
            zero      <= (mul_product == '0);
            overflow  <= 1'b0;
            illegal   <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe at WIDTH=32.
// Expectations follow the build: with ALU_PIPE_MUL_EN defined MUL is checked
// for its 33-edge latency and product; otherwise opcode 1010 must be illegal.
module tb_alu_pipe;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  operation;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        zero;
    logic        overflow;
    logic        illegal;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    alu_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operation (operation),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one request, expect acceptance on the next edge and the result
    // one edge later (latency 1). Called #1 after a rising edge.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input logic exp_z, input logic exp_o, input logic exp_i);
        operation = op;
        A         = a;
        B         = b;
        in_valid  = 1'b1;
        #1;
        check({tag, ".rdy"}, in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, ".vld"}, out_valid, 1);
        check({tag, ".res"}, ALUResult, exp_res);
        check({tag, ".zero"}, zero, exp_z);
        check({tag, ".ovf"}, overflow, exp_o);
        check({tag, ".ill"}, illegal, exp_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned edges;
        logic        saw_valid;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        operation = 4'b0000;
        A         = '0;
        B         = '0;

        // Asynchronous reset: outputs clear before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst.vld", out_valid, 0);
        check("rst.res", ALUResult, 0);
        check("rst.zero", zero, 0);
        check("rst.ovf", overflow, 0);
        check("rst.ill", illegal, 0);
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;

        // First request accepted on the first edge after release, then back-to-back.
        do_op("add",   OP_ADD,  32'd197, -32'sd237, 32'hFFFF_FFD8, 0, 0, 0);
        do_op("sub",   OP_SUB,  32'd197, -32'sd237, 32'd434,       0, 0, 0);
        do_op("slt",   OP_SLT,  32'd197, -32'sd237, 32'd0,         1, 0, 0);
        do_op("sltu",  OP_SLTU, 32'd197, -32'sd237, 32'd1,         0, 0, 0);
        do_op("nor",   OP_NOR,  32'd197, -32'sd237, 32'h0000_0028, 0, 0, 0);
        do_op("sra",   OP_SRA,  -32'sd237, 32'd4,   32'hFFFF_FFF1, 0, 0, 0);
        do_op("addov", OP_ADD,  32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0, 1, 0);
        do_op("subov", OP_SUB,  32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 0, 1, 0);
        do_op("subz",  OP_SUB,  32'd5, 32'd5,       32'd0,         1, 0, 0);
        do_op("and",   OP_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 0, 0, 0);
        do_op("or",    OP_OR,   32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 0, 0, 0);
        do_op("xor",   OP_XOR,  32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 0, 0, 0);
        do_op("sll",   OP_SLL,  32'd1, 32'h0000_0023,  32'd8,         0, 0, 0);
        do_op("srl",   OP_SRL,  32'h8000_0000, 32'd31, 32'd1,         0, 0, 0);
        do_op("ill_b", 4'b1011, 32'd3, 32'd4,       32'd0,         1, 0, 1);
        do_op("ill_f", 4'b1111, 32'hFFFF_FFFF, 32'd1, 32'd0,       1, 0, 1);

        // Drain with nothing new: out_valid clears.
        @(posedge clk);
        #1;
        check("drain.vld", out_valid, 0);

`ifdef ALU_PIPE_MUL_EN
        operation = OP_MUL;
        A         = 32'd197;
        B         = -32'sd237;
        in_valid  = 1'b1;
        #1;
        check("mul.rdy", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        edges    = 0;
        while (!out_valid && edges < 100) begin
            check("mul.busy_rdy", in_ready, 0);
            @(posedge clk);
            #1;
            edges++;
        end
        check("mul.lat", edges, 33);
        check("mul.res", ALUResult, 32'hFFFF_499F);
        check("mul.ill", illegal, 0);
        check("mul.ovf", overflow, 0);
        @(posedge clk);
        #1;

        // Abort a multiply with reset after 10 edges.
        operation = OP_MUL;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mabort.busy", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("mabort.vld", out_valid, 0);
        @(posedge clk);
        #4 rst_n = 1'b1;
        #1;
        check("mabort.rdy", in_ready, 1);
        saw_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("mabort.noresult", saw_valid, 0);
`else
        do_op("mul_ill", 4'b1010, 32'd197, -32'sd237, 32'd0, 1, 0, 1);
        @(posedge clk);
        #1;
`endif

        // Backpressure: result held while the consumer stalls.
        do_op("bp.first", OP_ADD, 32'd1, 32'd2, 32'd3, 0, 0, 0);
        out_ready = 1'b0;
        operation = OP_ADD;
        A         = 32'd10;
        B         = 32'd20;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("bp.rdy", in_ready, 0);
            check("bp.vld", out_valid, 1);
            check("bp.res", ALUResult, 3);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp.rdy_release", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp.swap_vld", out_valid, 1);
        check("bp.swap_res", ALUResult, 30);
        @(posedge clk);
        #1;
        check("bp.drain", out_valid, 0);

        // Reset with a result pending clears it immediately.
        out_ready = 1'b0;
        do_op("rp.add", OP_ADD, 32'd7, 32'd8, 32'd15, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("rp.vld", out_valid, 0);
        check("rp.res", ALUResult, 0);
        @(posedge clk);
        #4 rst_n = 1'b1;
        out_ready = 1'b1;
        do_op("rp.after", OP_XOR, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
